// File: rtl/calc_pkg.sv
// Shared keypad/calculator definitions: digit code decode and the operand-entry state set.
package calc_pkg;

    localparam logic [3:0] ZERO_CODE = 4'b1111;

    typedef enum logic [1:0] {ENTRY, CONVERT, DONE} state_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] value;
    } digit_t;

    // The keypad encodes zero as all-ones so that 4'b0000 can mean "no key".
    function automatic digit_t decode_digit(input logic [3:0] code);
        digit_t d;
        d.legal = 1'b0;
        d.value = 4'd0;
        if (code == ZERO_CODE) begin
            d.legal = 1'b1;
        end else if (code >= 4'd1 && code <= 4'd9) begin
            d.legal = 1'b1;
            d.value = code;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_to_bin_serial.sv
// Serial BCD-to-binary converter: one nibble per cycle, most significant first, Horner form.
module bcd_to_bin_serial #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [4*DIGITS-1:0] bcd,
    output logic                busy,
    output logic                done,
    output logic [BIN_W-1:0]    result
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic             busy_q;
    logic [IDX_W-1:0] idx;
    logic [BIN_W-1:0] acc;
    logic [3:0]       nibble;
    logic [BIN_W-1:0] acc_next;

    assign nibble   = 4'(bcd >> {idx, 2'b00});
    assign acc_next = (acc << 3) + (acc << 1) + BIN_W'(nibble);

    // done marks the final step; result is that step's value so the caller can latch it.
    assign busy   = busy_q;
    assign done   = busy_q && (idx == '0);
    assign result = acc_next;

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            busy_q <= 1'b0;
            idx    <= '0;
            acc    <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            idx    <= IDX_W'(DIGITS - 1);
            acc    <= '0;
        end else if (busy_q) begin
            acc <= acc_next;
            if (idx == '0) busy_q <= 1'b0;
            else           idx    <= idx - 1'b1;
        end
    end

endmodule

// File: rtl/operand_entry.sv
// Keypad operand entry: edge-detected digit shift register with backspace/clear, serial BCD->binary on commit.
module operand_entry
    import calc_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14,
    parameter int CNT_W  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          digit_in,
    input  logic                digit_en,
    input  logic                clear,
    input  logic                backspace,
    input  logic                commit,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic [CNT_W-1:0]    digit_count,
    output logic                full,
    output logic                busy,
    output logic                out_valid,
    output logic [BIN_W-1:0]    bin_out
);

    state_t              state, state_next;
    logic                en_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [BIN_W-1:0]    bin_q;
    logic                valid_q;
    digit_t              dec;
    logic                dig_edge;
    logic                full_q;
    logic                conv_start;
    logic                conv_busy;
    logic                conv_done;
    logic [BIN_W-1:0]    conv_result;

    assign dec        = decode_digit(digit_in);
    assign dig_edge   = digit_en && !en_q;
    assign full_q     = (cnt_q == CNT_W'(DIGITS));
    assign conv_start = (state == ENTRY) && commit && !clear;

    bcd_to_bin_serial #(.DIGITS(DIGITS), .BIN_W(BIN_W)) u_conv (
        .clk    (clk),
        .reset  (reset),
        .start  (conv_start),
        .abort  (clear),
        .bcd    (bcd_q),
        .busy   (conv_busy),
        .done   (conv_done),
        .result (conv_result)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ENTRY;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ENTRY:   if (commit)    state_next = CONVERT;
            CONVERT: if (conv_done) state_next = DONE;
            DONE:    if (out_ready) state_next = ENTRY;
            default:                state_next = ENTRY;
        endcase
        if (clear) state_next = ENTRY;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q    <= 1'b0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            en_q <= digit_en;
            if (clear) begin
                bcd_q   <= '0;
                cnt_q   <= '0;
                bin_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                case (state)
                    ENTRY: begin
                        if (commit) begin
                            // operand stays frozen while the converter walks it
                        end else if (backspace) begin
                            if (cnt_q != '0) begin
                                bcd_q <= bcd_q >> 4;
                                cnt_q <= cnt_q - CNT_W'(1);
                            end
                        end else if (dig_edge && dec.legal && !full_q &&
                                     !(dec.value == 4'd0 && cnt_q == '0)) begin
                            bcd_q <= (bcd_q << 4) | (4*DIGITS)'(dec.value);
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    CONVERT: begin
                        if (conv_done) begin
                            bin_q   <= conv_result;
                            valid_q <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (out_ready) begin
                            valid_q <= 1'b0;
                            bcd_q   <= '0;
                            cnt_q   <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bcd_out     = bcd_q;
    assign digit_count = cnt_q;
    assign full        = full_q;
    assign busy        = conv_busy;
    assign out_valid   = valid_q;
    assign bin_out     = bin_q;

endmodule

// File: tb/tb_operand_entry.sv
// Self-checking bench for operand_entry: digit-list model checked every cycle plus literal pins.
module tb_operand_entry;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;
    localparam int CNT_W  = 3;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [3:0]          digit_in = 4'd0;
    logic                digit_en = 1'b0;
    logic                clear = 1'b0;
    logic                backspace = 1'b0;
    logic                commit = 1'b0;
    logic                out_ready = 1'b0;
    logic [4*DIGITS-1:0] bcd_out;
    logic [CNT_W-1:0]    digit_count;
    logic                full;
    logic                busy;
    logic                out_valid;
    logic [BIN_W-1:0]    bin_out;

    operand_entry #(.DIGITS(DIGITS), .BIN_W(BIN_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .digit_in    (digit_in),
        .digit_en    (digit_en),
        .clear       (clear),
        .backspace   (backspace),
        .commit      (commit),
        .out_ready   (out_ready),
        .bcd_out     (bcd_out),
        .digit_count (digit_count),
        .full        (full),
        .busy        (busy),
        .out_valid   (out_valid),
        .bin_out     (bin_out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit started  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: operand is a list of decimal digits (oldest first); phase 0=entry 1=converting 2=result held.
    int  digs[$];
    int  phase = 0;
    int  conv_cycles = 0;
    int  m_bin = 0;
    bit  m_valid = 0;
    bit  prev_en = 0;

    function automatic logic [31:0] m_bcd();
        logic [31:0] v = 0;
        foreach (digs[i]) v = (v << 4) | 32'(digs[i]);
        return v;
    endfunction

    function automatic int m_value();
        int v = 0;
        foreach (digs[i]) v = v * 10 + digs[i];
        return v;
    endfunction

    always @(posedge clk) begin
        bit edge_seen;
        int d;
        edge_seen = digit_en && !prev_en;
        prev_en   = digit_en;
        if (reset) begin
            digs.delete(); phase = 0; m_bin = 0; m_valid = 0; prev_en = 0;
        end else if (clear) begin
            digs.delete(); phase = 0; m_bin = 0; m_valid = 0;
        end else if (phase == 0) begin
            if (commit) begin
                phase = 1; conv_cycles = 0;
            end else if (backspace) begin
                if (digs.size() > 0) void'(digs.pop_back());
            end else if (edge_seen) begin
                d = -1;
                if (digit_in == 4'hF) d = 0;
                else if (digit_in >= 1 && digit_in <= 9) d = int'(digit_in);
                if (d >= 0 && !(d == 0 && digs.size() == 0) && digs.size() < DIGITS)
                    digs.push_back(d);
            end
        end else if (phase == 1) begin
            conv_cycles++;
            if (conv_cycles == DIGITS) begin
                phase = 2; m_valid = 1; m_bin = m_value();
            end
        end else if (out_ready) begin
            phase = 0; m_valid = 0; digs.delete();
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("bcd_out",     32'(bcd_out),     m_bcd());
            chk("digit_count", 32'(digit_count), 32'(digs.size()));
            chk("full",        32'(full),        32'(digs.size() == DIGITS));
            chk("busy",        32'(busy),        32'(phase == 1));
            chk("out_valid",   32'(out_valid),   32'(m_valid));
            chk("bin_out",     32'(bin_out),     32'(m_bin));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] code, input int hold);
        digit_in = code;
        digit_en = 1'b1;
        repeat (hold) tick();
        digit_en = 1'b0;
        tick();
    endtask

    task automatic pulse_clear();
        clear = 1'b1; tick(); clear = 1'b0; tick();
    endtask

    task automatic pulse_backspace();
        backspace = 1'b1; tick(); backspace = 1'b0; tick();
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 12) begin tick(); n++; end
        if (!out_valid) begin
            checks++; failures++;
            $display("FAIL %s: out_valid never rose within 12 cycles", name);
        end
    endtask

    initial begin
        int k;
        int bc;
        bit seen;

        @(posedge clk);
        tick();
        started = 1;
        chk("rst_bcd", 32'(bcd_out), 0);
        chk("rst_valid", 32'(out_valid), 0);
        reset = 1'b0;
        tick();

        // 1,2,3 then commit with out_ready already high
        out_ready = 1'b1;
        press(4'd1, 1); press(4'd2, 1); press(4'd3, 1);
        chk("t1_bcd", 32'(bcd_out), 32'h0123);
        chk("t1_cnt", 32'(digit_count), 3);
        commit = 1'b1; tick(); commit = 1'b0;
        k = 1; bc = 0;
        while (!out_valid && k < 12) begin
            if (busy) bc++;
            tick(); k++;
        end
        chk("t1_busy_cycles", 32'(bc), 4);
        chk("t1_valid_latency", 32'(k), 5);
        chk("t1_bin", 32'(bin_out), 123);
        tick();
        chk("t1_bcd_after", 32'(bcd_out), 0);
        chk("t1_valid_after", 32'(out_valid), 0);

        // leading zeros
        press(4'hF, 1); press(4'hF, 1); press(4'd7, 1);
        chk("t2_cnt", 32'(digit_count), 1);
        chk("t2_bcd", 32'(bcd_out), 32'h0007);
        pulse_clear();

        // overflow and illegal code
        for (int i = 1; i <= 5; i++) press(4'(i), 1);
        chk("t3_bcd", 32'(bcd_out), 32'h1234);
        chk("t3_full", 32'(full), 1);
        press(4'hC, 1);
        chk("t3_illegal", 32'(bcd_out), 32'h1234);
        pulse_clear();
        press(4'h0, 1);
        press(4'hA, 1);
        chk("t3_illegal_cnt", 32'(digit_count), 0);

        // held key, then backspace twice
        press(4'd5, 10);
        chk("t4_held", 32'(bcd_out), 32'h0005);
        pulse_backspace();
        chk("t4_bs_bcd", 32'(bcd_out), 0);
        chk("t4_bs_cnt", 32'(digit_count), 0);
        pulse_backspace();
        chk("t4_bs2", 32'(digit_count), 0);

        // handshake stall with ignored keypresses
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) press(4'd9, 1);
        commit = 1'b1; tick(); commit = 1'b0;
        wait_valid("t5_wait");
        chk("t5_bin", 32'(bin_out), 9999);
        for (int i = 0; i < 10; i++) begin
            press(4'd3, 1);
            backspace = (i == 4); commit = (i == 6);
            tick();
            backspace = 1'b0; commit = 1'b0;
        end
        chk("t5_held_valid", 32'(out_valid), 1);
        chk("t5_frozen", 32'(bcd_out), 32'h9999);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("t5_xfer_valid", 32'(out_valid), 0);
        chk("t5_xfer_bcd", 32'(bcd_out), 0);
        press(4'd4, 1);
        chk("t5_resume", 32'(bcd_out), 32'h0004);
        pulse_clear();

        // clear in the second conversion cycle
        press(4'd1, 1); press(4'd2, 1);
        commit = 1'b1; tick(); commit = 1'b0;
        tick();
        clear = 1'b1; tick(); clear = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid || busy) seen = 1;
            tick();
        end
        chk("t6_no_valid", 32'(seen), 0);
        chk("t6_bcd", 32'(bcd_out), 0);

        // reset while a result is held
        press(4'd4, 1);
        commit = 1'b1; tick(); commit = 1'b0;
        wait_valid("t7_wait");
        chk("t7_bin", 32'(bin_out), 4);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t7_valid", 32'(out_valid), 0);
        chk("t7_bin_rst", 32'(bin_out), 0);
        chk("t7_bcd", 32'(bcd_out), 0);
        tick(); tick();

        started = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
